// File: rtl/rc4_keystream_gen.sv
// RC4 keystream generator: runtime key length, valid/ready key and keystream
// handshakes, optional drop of the first DROP_N bytes, and synchronous rekey.
module rc4_keystream_gen #(
  parameter int MAX_KEY_LEN = 16,
  parameter int DROP_N      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_byte,
  input  logic       key_last,
  output logic       key_ready,
  input  logic       rekey,
  output logic       ks_valid,
  input  logic       ks_ready,
  output logic [7:0] ks_byte,
  output logic       ks_active
);

  localparam int            KW       = (MAX_KEY_LEN > 1) ? $clog2(MAX_KEY_LEN) : 1;
  localparam logic [KW-1:0] KIDX_MAX = KW'(MAX_KEY_LEN - 1);
  localparam logic [15:0]   DROP_LIM = 16'(DROP_N);

  typedef enum logic [2:0] {
    ST_KEYLOAD   = 3'd0,
    ST_INIT      = 3'd1,
    ST_KSA_J     = 3'd2,
    ST_KSA_SWAP  = 3'd3,
    ST_PRGA_J    = 3'd4,
    ST_PRGA_SWAP = 3'd5,
    ST_WAIT      = 3'd6
  } state_t;

  state_t        state;
  logic [7:0]    s_mem   [0:255];
  logic [7:0]    key_mem [0:MAX_KEY_LEN-1];
  logic [7:0]    i;
  logic [7:0]    j;
  logic [KW-1:0] kidx;
  logic [KW:0]   klen;
  logic [15:0]   drop_cnt;

  logic [7:0]    s_i;
  logic [7:0]    s_j;
  logic [7:0]    k_sum;
  logic [7:0]    ks_next;
  logic          key_acc;
  logic          key_end;
  logic          kidx_wrap;

  assign s_i       = s_mem[i];
  assign s_j       = s_mem[j];
  assign k_sum     = s_i + s_j;
  assign key_acc   = key_valid && key_ready;
  assign key_end   = key_last || (kidx == KIDX_MAX);
  assign kidx_wrap = (({1'b0, kidx} + 1'b1) == klen);

  // The output lookup must see S after this cycle's swap; forward the two
  // swapped entries instead of waiting a cycle for the array to update.
  always_comb begin
    ks_next = s_mem[k_sum];
    if (k_sum == i)
      ks_next = s_j;
    else if (k_sum == j)
      ks_next = s_i;
  end

  assign ks_active = (state == ST_PRGA_J) || (state == ST_PRGA_SWAP) || (state == ST_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_KEYLOAD;
      i         <= 8'd0;
      j         <= 8'd0;
      kidx      <= '0;
      drop_cnt  <= 16'd0;
      ks_valid  <= 1'b0;
      ks_byte   <= 8'h00;
      key_ready <= 1'b1;
    end else if (rekey) begin
      state     <= ST_KEYLOAD;
      i         <= 8'd0;
      j         <= 8'd0;
      kidx      <= '0;
      ks_valid  <= 1'b0;
      key_ready <= 1'b1;
    end else begin
      case (state)
        ST_KEYLOAD: begin
          if (key_acc) begin
            if (key_end) begin
              kidx      <= '0;
              i         <= 8'd0;
              key_ready <= 1'b0;
              state     <= ST_INIT;
            end else begin
              kidx <= kidx + 1'b1;
            end
          end
        end
        ST_INIT: begin
          if (i == 8'hFF) begin
            i     <= 8'd0;
            j     <= 8'd0;
            state <= ST_KSA_J;
          end else begin
            i <= i + 8'd1;
          end
        end
        ST_KSA_J: begin
          j     <= j + s_i + key_mem[kidx];
          kidx  <= kidx_wrap ? '0 : kidx + 1'b1;
          state <= ST_KSA_SWAP;
        end
        ST_KSA_SWAP: begin
          if (i == 8'hFF) begin
            i        <= 8'd1;
            j        <= 8'd0;
            drop_cnt <= 16'd0;
            state    <= ST_PRGA_J;
          end else begin
            i     <= i + 8'd1;
            state <= ST_KSA_J;
          end
        end
        ST_PRGA_J: begin
          j     <= j + s_i;
          state <= ST_PRGA_SWAP;
        end
        ST_PRGA_SWAP: begin
          if (drop_cnt != DROP_LIM) begin
            drop_cnt <= drop_cnt + 16'd1;
            i        <= i + 8'd1;
            state    <= ST_PRGA_J;
          end else begin
            ks_byte  <= ks_next;
            ks_valid <= 1'b1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ks_ready) begin
            ks_valid <= 1'b0;
            i        <= i + 8'd1;
            state    <= ST_PRGA_J;
          end
        end
        default: begin
          state     <= ST_KEYLOAD;
          i         <= 8'd0;
          j         <= 8'd0;
          kidx      <= '0;
          ks_valid  <= 1'b0;
          key_ready <= 1'b1;
        end
      endcase
    end
  end

  // Key storage and length: data only, never reset.
  always_ff @(posedge clk) begin
    if (!rekey && (state == ST_KEYLOAD) && key_acc) begin
      key_mem[kidx] <= key_byte;
      if (key_end)
        klen <= {1'b0, kidx} + 1'b1;
    end
  end

  // S-box: identity fill during INIT, swaps during KSA and PRGA.
  always_ff @(posedge clk) begin
    if (!rekey) begin
      case (state)
        ST_INIT: s_mem[i] <= i;
        ST_KSA_SWAP, ST_PRGA_SWAP: begin
          s_mem[i] <= s_j;
          s_mem[j] <= s_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_keystream_gen.sv
// Bench for rc4_keystream_gen: three instances (default, DROP_N=3, MAX_KEY_LEN=4)
// checked against known vectors and a textbook RC4 model.
module tb_rc4_keystream_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid [3];
  logic [7:0] key_byte  [3];
  logic       key_last  [3];
  logic       key_ready [3];
  logic       rekey     [3];
  logic       ks_valid  [3];
  logic       ks_ready  [3];
  logic [7:0] ks_byte   [3];
  logic       ks_active [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] got_q [$];
  int         tv_q  [$];
  logic [7:0] exp_q [$];

  typedef struct {
    logic [15:0][7:0] key;
    int               len;
    int               n;
    logic [9:0][7:0]  exp;
  } vec_t;

  rc4_keystream_gen #(.MAX_KEY_LEN(16), .DROP_N(0)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid[0]), .key_byte(key_byte[0]),
    .key_last(key_last[0]), .key_ready(key_ready[0]), .rekey(rekey[0]),
    .ks_valid(ks_valid[0]), .ks_ready(ks_ready[0]), .ks_byte(ks_byte[0]),
    .ks_active(ks_active[0]));

  rc4_keystream_gen #(.MAX_KEY_LEN(16), .DROP_N(3)) dut_drop (
    .clk(clk), .rst(rst), .key_valid(key_valid[1]), .key_byte(key_byte[1]),
    .key_last(key_last[1]), .key_ready(key_ready[1]), .rekey(rekey[1]),
    .ks_valid(ks_valid[1]), .ks_ready(ks_ready[1]), .ks_byte(ks_byte[1]),
    .ks_active(ks_active[1]));

  rc4_keystream_gen #(.MAX_KEY_LEN(4), .DROP_N(0)) dut_m4 (
    .clk(clk), .rst(rst), .key_valid(key_valid[2]), .key_byte(key_byte[2]),
    .key_last(key_last[2]), .key_ready(key_ready[2]), .rekey(rekey[2]),
    .ks_valid(ks_valid[2]), .ks_ready(ks_ready[2]), .ks_byte(ks_byte[2]),
    .ks_active(ks_active[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Textbook RC4: KSA, then PRGA with the output lookup after the swap.
  function automatic void rc4_ref(input logic [15:0][7:0] k, input int klen,
                                  input int drop, input int n);
    int s [256];
    int a, b, t;
    for (int x = 0; x < 256; x++) s[x] = x;
    b = 0;
    for (int x = 0; x < 256; x++) begin
      b = (b + s[x] + int'(k[x % klen])) % 256;
      t = s[x]; s[x] = s[b]; s[b] = t;
    end
    a = 0; b = 0;
    exp_q.delete();
    for (int m = 0; m < drop + n; m++) begin
      a = (a + 1) % 256;
      b = (b + s[a]) % 256;
      t = s[a]; s[a] = s[b]; s[b] = t;
      if (m >= drop) exp_q.push_back(8'(s[(s[a] + s[b]) % 256]));
    end
  endfunction

  task automatic load_key(input int d, input logic [15:0][7:0] k, input int len,
                          input bit use_last, output int e0, output int accepted);
    int idx;
    idx = 0; accepted = 0; e0 = -1;
    for (int c = 0; c < 64 && idx < len; c++) begin
      @(negedge clk);
      if (!key_ready[d]) begin
        if (idx > 0) break;
        continue;
      end
      key_valid[d] = 1'b1;
      key_byte[d]  = k[idx];
      key_last[d]  = use_last && (idx == len - 1);
      @(posedge clk);
      idx++; accepted++;
      #1 e0 = cyc;
    end
    @(negedge clk);
    key_valid[d] = 1'b0;
    key_last[d]  = 1'b0;
  endtask

  task automatic collect(input int d, input int n, input int pct, input int limit);
    logic [7:0] held;
    bit stalled;
    int c;
    got_q.delete(); tv_q.delete();
    stalled = 0; c = 0; held = 8'h00;
    while (got_q.size() < n && c < limit) begin
      @(negedge clk);
      c++;
      if (ks_valid[d]) begin
        if (stalled) check("hold_stable", 32'(ks_byte[d]), 32'(held));
        else tv_q.push_back(cyc);
        held = ks_byte[d];
        ks_ready[d] = ($urandom_range(0, 99) < pct);
        if (ks_ready[d]) begin
          got_q.push_back(ks_byte[d]);
          stalled = 0;
        end else begin
          stalled = 1;
        end
      end else begin
        if (stalled) check("valid_hold", 32'(ks_valid[d]), 32'd1);
        ks_ready[d] = ($urandom_range(0, 99) < pct);
        stalled = 0;
      end
    end
    if (got_q.size() < n) begin
      checks++; errors++;
      $display("FAIL collect_timeout: got %0d bytes, expected %0d", got_q.size(), n);
    end
    @(negedge clk);
    ks_ready[d] = 1'b0;
  endtask

  task automatic cmp_bytes(input string name, input int n);
    for (int k = 0; k < n && k < got_q.size(); k++)
      check($sformatf("%s[%0d]", name, k), 32'(got_q[k]), 32'(exp_q[k]));
  endtask

  task automatic wait_valid(input int d, input int limit);
    int c;
    c = 0;
    while (!ks_valid[d] && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (!ks_valid[d]) begin
      checks++; errors++;
      $display("FAIL wait_valid_timeout: ks_valid stayed 0 for %0d cycles", limit);
    end
  endtask

  task automatic rekey_pulse(input int d);
    @(negedge clk); rekey[d] = 1'b1;
    @(negedge clk); rekey[d] = 1'b0;
  endtask

  logic [15:0][7:0] key_k;
  logic [15:0][7:0] rk;
  vec_t             vt [3];
  int               e0, acc, rl, pct, vcount;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      key_valid[d] = 0; key_byte[d] = 0; key_last[d] = 0; rekey[d] = 0; ks_ready[d] = 0;
    end
    key_k = 128'h79654B;
    vt[0].key = 128'h79654B;       vt[0].len = 3; vt[0].n = 10;
    vt[0].exp = 80'h19A772CA34B781779FEB;
    vt[1].key = 128'h746572636553; vt[1].len = 6; vt[1].n = 8;
    vt[1].exp = 80'h597BA83C056BD404;
    vt[2].key = 128'h696B6957;     vt[2].len = 4; vt[2].n = 6;
    vt[2].exp = 80'hB7416DDB4460;

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_ks_valid",  32'(ks_valid[d]),  32'd0);
      check("rst_ks_byte",   32'(ks_byte[d]),   32'd0);
      check("rst_key_ready", 32'(key_ready[d]), 32'd1);
      check("rst_ks_active", 32'(ks_active[d]), 32'd0);
    end
    rst = 1'b0;

    // Known vectors; the second rekey doubles as the Secret -> Wiki switch.
    for (int v = 0; v < 3; v++) begin
      if (v > 0) begin
        rekey_pulse(0);
        check("rekey_key_ready", 32'(key_ready[0]), 32'd1);
        check("rekey_ks_valid",  32'(ks_valid[0]),  32'd0);
      end
      load_key(0, vt[v].key, vt[v].len, 1, e0, acc);
      collect(0, vt[v].n, 100, 2000);
      exp_q.delete();
      for (int k = 0; k < vt[v].n; k++) exp_q.push_back(vt[v].exp[k]);
      cmp_bytes($sformatf("vec%0d", v), vt[v].n);
      if (v == 0 && tv_q.size() == vt[v].n) begin
        check("first_valid_latency", 32'(tv_q[0] - e0), 32'd770);
        for (int k = 1; k < vt[v].n; k++)
          check("byte_spacing", 32'(tv_q[k] - tv_q[k-1]), 32'd3);
      end
    end

    // Drop of three bytes.
    load_key(1, key_k, 3, 1, e0, acc);
    collect(1, 7, 100, 2000);
    rc4_ref(key_k, 3, 3, 7);
    cmp_bytes("drop3", 7);
    if (got_q.size() > 0) check("drop3_first", 32'(got_q[0]), 32'h81);
    if (tv_q.size() > 0) check("drop3_latency", 32'(tv_q[0] - e0), 32'd776);

    // Backpressure on "Key".
    rekey_pulse(0);
    load_key(0, key_k, 3, 1, e0, acc);
    collect(0, 10, 30, 4000);
    exp_q.delete();
    for (int k = 0; k < 10; k++) exp_q.push_back(vt[0].exp[k]);
    cmp_bytes("backpressure", 10);

    // Key length capped at MAX_KEY_LEN=4, key_last never asserted.
    rk = 128'h0504030201;
    load_key(2, rk, 5, 0, e0, acc);
    check("m4_accepted", 32'(acc), 32'd4);
    check("m4_key_ready_low", 32'(key_ready[2]), 32'd0);
    collect(2, 6, 100, 2000);
    rc4_ref(rk, 4, 0, 6);
    cmp_bytes("m4", 6);
    if (tv_q.size() > 0) check("m4_latency", 32'(tv_q[0] - e0), 32'd770);

    // rekey together with a key_last byte: the byte is dropped.
    rekey_pulse(0);
    @(negedge clk);
    key_valid[0] = 1; key_byte[0] = 8'hAA; key_last[0] = 1; rekey[0] = 1;
    @(negedge clk);
    key_valid[0] = 0; key_last[0] = 0; rekey[0] = 0;
    check("rekey_accept_key_ready", 32'(key_ready[0]), 32'd1);
    load_key(0, key_k, 3, 1, e0, acc);
    collect(0, 3, 100, 2000);
    rc4_ref(key_k, 3, 0, 3);
    cmp_bytes("after_discard", 3);

    // rekey together with an output handshake.
    wait_valid(0, 20);
    check("wait_byte4", 32'(ks_byte[0]), 32'h81);
    ks_ready[0] = 1; rekey[0] = 1;
    @(negedge clk);
    ks_ready[0] = 0; rekey[0] = 0;
    check("rekey_hs_ks_valid",  32'(ks_valid[0]),  32'd0);
    check("rekey_hs_key_ready", 32'(key_ready[0]), 32'd1);
    check("rekey_hs_ks_active", 32'(ks_active[0]), 32'd0);
    vcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (ks_valid[0]) vcount++;
    end
    check("no_bytes_after_rekey", 32'(vcount), 32'd0);
    load_key(0, key_k, 3, 1, e0, acc);
    collect(0, 3, 100, 2000);
    cmp_bytes("after_rekey_hs", 3);

    // Asynchronous reset mid-KSA on dut, and while dut_drop waits in WAIT.
    rekey_pulse(0);
    load_key(0, key_k, 3, 1, e0, acc);
    repeat (400) @(negedge clk);
    check("ksa_key_ready",   32'(key_ready[0]), 32'd0);
    check("ksa_ks_active",   32'(ks_active[0]), 32'd0);
    check("drop_wait_valid", 32'(ks_valid[1]),  32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_key_ready",   32'(key_ready[0]), 32'd1);
    check("async_ks_valid",    32'(ks_valid[1]),  32'd0);
    check("async_ks_byte",     32'(ks_byte[1]),   32'd0);
    check("async_ks_active",   32'(ks_active[1]), 32'd0);
    check("async_m4_key_ready", 32'(key_ready[2]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    load_key(0, key_k, 3, 1, e0, acc);
    collect(0, 3, 100, 2000);
    rc4_ref(key_k, 3, 0, 3);
    cmp_bytes("after_reset", 3);

    // Random keys and backpressure against the model.
    for (int r = 0; r < 8; r++) begin
      int d;
      d = (r < 4) ? 0 : (r < 6) ? 1 : 2;
      for (int b = 0; b < 16; b++) rk[b] = 8'($urandom);
      rl  = (d == 2) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 16));
      pct = int'($urandom_range(30, 100));
      rekey_pulse(d);
      load_key(d, rk, rl, 1, e0, acc);
      collect(d, 8, pct, 4000);
      rc4_ref(rk, rl, (d == 1) ? 3 : 0, 8);
      cmp_bytes($sformatf("rand%0d", r), 8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
